// File: rtl/countdown_timer_pkg.sv
// Countdown timer shared definitions:
// register offsets and CTRL/STATUS bit indices.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_LOAD   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

endpackage

// File: rtl/countdown_timer_if.sv
// CPU register bus of the countdown timer:
// address, write data/strobe, read data and irq.
interface countdown_timer_if;

  logic [1:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        irq;

  modport master (
    output A, WD, WE,
    input  RD, irq
  );

  modport slave (
    input  A, WD, WE,
    output RD, irq
  );

endinterface

// File: rtl/countdown_timer_prescaler.sv
// Prescaler for the countdown timer: one-cycle tick
// every F_DIV+1 enabled cycles, held at 0 when idle.
module timer_prescaler #(
  parameter int F_DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W =
    (F_DIV > 0) ? $clog2(F_DIV + 1) : 1;
  localparam logic [W-1:0] TERM = W'(F_DIV);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/countdown_timer.sv
// Memory-mapped countdown timer with auto-reload.
// Define TIMER_IRQ_EN to enable CTRL.IE and irq.
module countdown_timer #(
  parameter int F_DIV = 50_000
) (
  input logic         clk,
  input logic         rst,
  countdown_timer_if.slave bus
);

  import countdown_timer_pkg::*;

  logic        en;
  logic        ar;
  logic        ie;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        exp_q;
  logic        tick;
  logic        expire;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
  logic [31:0] rd;

  timer_prescaler #(
    .F_DIV(F_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign wr_ctrl   = bus.WE && bus.A == REG_CTRL;
  assign wr_load   = bus.WE && bus.A == REG_LOAD;
  assign wr_count  = bus.WE && bus.A == REG_COUNT;
  assign wr_status = bus.WE && bus.A == REG_STATUS;
  assign expire    = tick && count_q == 32'd1;

  // CPU writes win over tick updates; expiry wins over W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      ar      <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en <= bus.WD[CTRL_EN];
        ar <= bus.WD[CTRL_AR];
      end else if (expire && !ar) begin
        en <= 1'b0;
      end
      if (wr_load) begin
        load_q <= bus.WD;
      end
      if (wr_count) begin
        count_q <= bus.WD;
      end else if (expire) begin
        count_q <= ar ? load_q : '0;
      end else if (tick && count_q > 32'd1) begin
        count_q <= count_q - 32'd1;
      end
      if (expire) begin
        exp_q <= 1'b1;
      end else if (wr_status &&
                   bus.WD[STATUS_EXP]) begin
        exp_q <= 1'b0;
      end
    end
  end

`ifdef TIMER_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie <= 1'b0;
    end else if (wr_ctrl) begin
      ie <= bus.WD[CTRL_IE];
    end
  end
  assign bus.irq = exp_q & ie;
`else
  assign ie      = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    rd = '0;
    unique case (reg_addr_e'(bus.A))
      REG_CTRL:   rd = {29'd0, ie, ar, en};
      REG_LOAD:   rd = load_q;
      REG_COUNT:  rd = count_q;
      REG_STATUS: rd = {31'd0, exp_q};
    endcase
  end

  assign bus.RD = rd;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (F_DIV=3)
// with a cycle-level reference model.
module tb_countdown_timer;

  import countdown_timer_pkg::*;

  localparam int FD = 3;

`ifdef TIMER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  countdown_timer_if bus ();

  countdown_timer #(
    .F_DIV(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_en;
  bit          m_ar;
  bit          m_ie;
  bit          m_exp;
  logic [31:0] m_load;
  logic [31:0] m_count;
  int          m_run;

  task automatic model_reset();
    m_en    = 0;
    m_ar    = 0;
    m_ie    = 0;
    m_exp   = 0;
    m_load  = '0;
    m_count = '0;
    m_run   = 0;
  endtask

  task automatic model_edge(
    input bit          we,
    input logic [1:0]  a,
    input logic [31:0] wd
  );
    bit tk;
    bit ex;
    tk = m_en && (m_run % (FD + 1) == FD);
    ex = tk && m_count == 1;
    m_run = m_en ? m_run + 1 : 0;
    if (ex) begin
      m_exp = 1;
      m_count = m_ar ? m_load : 0;
      if (!m_ar) m_en = 0;
    end else if (tk && m_count > 1) begin
      m_count = m_count - 1;
    end
    if (we && a == REG_STATUS && wd[0] && !ex)
      m_exp = 0;
    if (we && a == REG_COUNT) m_count = wd;
    if (we && a == REG_LOAD) m_load = wd;
    if (we && a == REG_CTRL) begin
      m_en = wd[0];
      m_ar = wd[1];
      m_ie = wd[2] & HAS_IRQ;
    end
  endtask

  task automatic cyc(
    input bit          we,
    input logic [1:0]  a,
    input logic [31:0] wd
  );
    bus.WE = we;
    bus.A  = a;
    bus.WD = wd;
    @(posedge clk);
    model_edge(we, a, wd);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, REG_CTRL, 32'd0);
  endtask

  task automatic rd(
    input  logic [1:0]  a,
    output logic [31:0] d
  );
    bus.A = a;
    #1;
    d = bus.RD;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, REG_LOAD, 32'd7);
    cyc(1, REG_COUNT, 32'd5);
    cyc(1, REG_CTRL, 32'd7);
    idle(6);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL pre_reset_count got %0d exp 4", d);
    end
    #1;
    rst = 1'b1;
    model_reset();
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d got %h exp 0",
                 r, d);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b exp 0",
               bus.irq);
    end
    #1;
    rst = 1'b0;
    idle(8);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_resume got %0d exp 0",
               d);
    end
    rd(REG_STATUS, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_exp got %0d exp 0", d);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    cyc(1, REG_COUNT, 32'd2);
    cyc(1, REG_CTRL, 32'd5);
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      rd(REG_STATUS, d);
      checks++;
      if (d !== 32'(i >= 8)) begin
        errors++;
        $display("FAIL oneshot_exp c%0d got %0d exp %0d",
                 i, d, i >= 8);
      end
    end
    checks++;
    if (bus.irq !== HAS_IRQ) begin
      errors++;
      $display("FAIL oneshot_irq got %b exp %b",
               bus.irq, HAS_IRQ);
    end
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_count got %0d exp 0", d);
    end
    rd(REG_CTRL, d);
    checks++;
    if (d !== {29'd0, HAS_IRQ, 2'b00}) begin
      errors++;
      $display("FAIL oneshot_ctrl got %h exp %h",
               d, {29'd0, HAS_IRQ, 2'b00});
    end
    cyc(1, REG_STATUS, 32'd1);
    cyc(1, REG_CTRL, 32'd0);
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    cyc(1, REG_LOAD, 32'd3);
    cyc(1, REG_COUNT, 32'd1);
    cyc(1, REG_CTRL, 32'd3);
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      rd(REG_STATUS, d);
      checks++;
      if (d !== 32'(i >= 4)) begin
        errors++;
        $display("FAIL ar_exp c%0d got %0d exp %0d",
                 i, d, i >= 4);
      end
      if (i >= 4) begin
        rd(REG_COUNT, d);
        checks++;
        if (d !== (i == 8 ? 32'd2 : 32'd3)) begin
          errors++;
          $display("FAIL ar_count c%0d got %0d", i, d);
        end
      end
    end
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL ar_ctrl got %h exp 3", d);
    end
    cyc(1, REG_CTRL, 32'd0);
    cyc(1, REG_STATUS, 32'd1);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    cyc(1, REG_COUNT, 32'd1);
    cyc(1, REG_CTRL, 32'd1);
    idle(3);
    cyc(1, REG_STATUS, 32'd1);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL w1c_race got %0d exp 1", d);
    end
    cyc(1, REG_STATUS, 32'd0);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL w0_keep got %0d exp 1", d);
    end
    cyc(1, REG_STATUS, 32'd1);
    rd(REG_STATUS, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL w1c_clear got %0d exp 0", d);
    end
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL w1c_en_off got %h exp 0", d);
    end
  endtask

  task automatic test_write_priority();
    logic [31:0] d;
    cyc(1, REG_COUNT, 32'h20);
    cyc(1, REG_CTRL, 32'd1);
    idle(3);
    cyc(1, REG_COUNT, 32'h10);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'h10) begin
      errors++;
      $display("FAIL wr_prio got %h exp 10", d);
    end
    idle(4);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'h0F) begin
      errors++;
      $display("FAIL wr_prio_next got %h exp 0f", d);
    end
    cyc(1, REG_CTRL, 32'd0);
  endtask

  task automatic test_idle_zero();
    logic [31:0] d;
    cyc(1, REG_COUNT, 32'd0);
    cyc(1, REG_CTRL, 32'd7);
    rd(REG_CTRL, d);
    checks++;
    if (d !== {29'd0, HAS_IRQ, 2'b11}) begin
      errors++;
      $display("FAIL idle_ctrl got %h", d);
    end
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      rd(REG_COUNT, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL idle_count c%0d got %h", i, d);
      end
      rd(REG_STATUS, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL idle_exp c%0d got %h", i, d);
      end
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL idle_irq c%0d got %b", i,
                 bus.irq);
      end
    end
    cyc(1, REG_CTRL, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] wd;
    logic [1:0]  a;
    logic [31:0] exp_v [4];
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        idle(1);
      end else begin
        a = 2'($urandom_range(0, 3));
        unique case (a)
          REG_CTRL:
            wd = $urandom_range(0, 7) | 32'd1;
          REG_STATUS:
            wd = 32'($urandom_range(0, 1));
          default:
            wd = ($urandom_range(0, 15) == 0) ?
                 $urandom : 32'($urandom_range(0, 6));
        endcase
        if ($urandom_range(0, 7) == 0)
          wd[31:1] = $urandom;
        cyc(1, a, wd);
      end
      exp_v[0] = {29'd0, m_ie, m_ar, m_en};
      exp_v[1] = m_load;
      exp_v[2] = m_count;
      exp_v[3] = {31'd0, m_exp};
      for (int r = 0; r < 4; r++) begin
        rd(2'(r), d);
        checks++;
        if (d !== exp_v[r]) begin
          errors++;
          $display("FAIL rand_reg%0d n%0d got %h exp %h",
                   r, n, d, exp_v[r]);
        end
      end
      checks++;
      if (bus.irq !== (m_exp & m_ie)) begin
        errors++;
        $display("FAIL rand_irq n%0d got %b exp %b",
                 n, bus.irq, m_exp & m_ie);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.A  = REG_CTRL;
    bus.WD = '0;
    bus.WE = 1'b0;
    model_reset();
    test_reset();
    test_oneshot();
    test_autoreload();
    test_w1c_race();
    test_write_priority();
    test_idle_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
